// File: rtl/ysyx_23060187_ctrl_pkg.sv
// Shared definitions for the multicycle control FSM: state encoding and the
// RV32I major-opcode constants, plus opcode classification helpers.
package ysyx_23060187_ctrl_pkg;

  typedef enum logic [3:0] {
    S_IDLE       = 4'd0,
    S_FETCH_REQ  = 4'd1,
    S_FETCH_WAIT = 4'd2,
    S_DECODE     = 4'd3,
    S_EXEC       = 4'd4,
    S_MEM_REQ    = 4'd5,
    S_MEM_WAIT   = 4'd6,
    S_WB         = 4'd7,
    S_HALT       = 4'd8,
    S_ERR        = 4'd9
  } state_t;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  function automatic logic opc_legal(input logic [6:0] opc);
    logic ok;
    case (opc)
      OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_BRANCH,
      OPC_LOAD, OPC_STORE, OPC_OP_IMM, OPC_OP, OPC_SYSTEM: ok = 1'b1;
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic logic opc_is_mem(input logic [6:0] opc);
    return (opc == OPC_LOAD) || (opc == OPC_STORE);
  endfunction

  // Instructions with no destination register must not strobe the register file.
  function automatic logic opc_writes_rd(input logic [6:0] opc);
    return !((opc == OPC_STORE) || (opc == OPC_BRANCH) || (opc == OPC_SYSTEM));
  endfunction

endpackage

// File: rtl/ysyx_23060187_wait_timer.sv
// Cycle counter for handshake wait states; flags the TIMEOUT-th consecutive
// cycle spent waiting so the controller can abort on that edge.
module ysyx_23060187_wait_timer #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic clear,
  input  logic run,
  output logic expired
);

  localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  logic [CW-1:0] count;

  // count holds completed wait cycles, so count == TIMEOUT-1 marks the
  // TIMEOUT-th cycle; the counter parks there instead of wrapping.
  assign expired = run && (count == CW'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (clear) begin
      count <= '0;
    end else if (run && !expired) begin
      count <= count + CW'(1);
    end
  end

endmodule

// File: rtl/ysyx_23060187_multicycle_ctrl.sv
// Multicycle instruction sequencer: fetch/decode/exec/mem/writeback FSM with
// handshake timeouts, sticky halt/error states and a retired-instruction count.
module ysyx_23060187_multicycle_ctrl
  import ysyx_23060187_ctrl_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [6:0]  opcode,
  input  logic        is_ebreak,
  output logic        ifu_req,
  input  logic        ifu_ready,
  input  logic        ifu_rvalid,
  output logic        ir_we,
  output logic        lsu_req,
  output logic        lsu_wen,
  input  logic        lsu_ready,
  input  logic        lsu_rvalid,
  output logic        rf_wen,
  output logic        pc_we,
  output logic        halt,
  output logic        err,
  output logic [3:0]  state,
  output logic [31:0] retired
);

  state_t      cur_state;
  logic [6:0]  op_q;
  logic [31:0] retired_q;
  logic        halt_q;
  logic        err_q;

  logic in_wait;
  logic advance;
  logic expired;
  logic timer_clear;

  assign in_wait = (cur_state == S_FETCH_REQ) || (cur_state == S_FETCH_WAIT) ||
                   (cur_state == S_MEM_REQ)   || (cur_state == S_MEM_WAIT);

  // Only the handshake belonging to the current wait state is looked at.
  always_comb begin
    advance = 1'b0;
    case (cur_state)
      S_FETCH_REQ:  advance = ifu_ready;
      S_FETCH_WAIT: advance = ifu_rvalid;
      S_MEM_REQ:    advance = lsu_ready;
      S_MEM_WAIT:   advance = lsu_rvalid;
      default:      advance = 1'b0;
    endcase
  end

  // Clearing while outside a wait state or on the leaving edge means every
  // wait state is entered with a zero count.
  assign timer_clear = rst || !in_wait || advance;

  ysyx_23060187_wait_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_wait_timer (
    .clk     (clk),
    .clear   (timer_clear),
    .run     (in_wait && !rst),
    .expired (expired)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      cur_state <= S_IDLE;
      op_q      <= '0;
      retired_q <= '0;
      halt_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      case (cur_state)
        S_IDLE: begin
          cur_state <= S_FETCH_REQ;
        end
        S_FETCH_REQ, S_FETCH_WAIT, S_MEM_REQ, S_MEM_WAIT: begin
          if (expired) begin
            cur_state <= S_ERR;
            err_q     <= 1'b1;
          end else if (advance) begin
            case (cur_state)
              S_FETCH_REQ:  cur_state <= S_FETCH_WAIT;
              S_FETCH_WAIT: cur_state <= S_DECODE;
              S_MEM_REQ:    cur_state <= S_MEM_WAIT;
              default:      cur_state <= S_WB;
            endcase
          end
        end
        S_DECODE: begin
          op_q <= opcode;
          if (is_ebreak) begin
            cur_state <= S_HALT;
            halt_q    <= 1'b1;
          end else if (!opc_legal(opcode)) begin
            cur_state <= S_ERR;
            err_q     <= 1'b1;
          end else begin
            cur_state <= S_EXEC;
          end
        end
        S_EXEC: begin
          cur_state <= opc_is_mem(op_q) ? S_MEM_REQ : S_WB;
        end
        S_WB: begin
          retired_q <= retired_q + 32'd1;
          cur_state <= S_FETCH_REQ;
        end
        S_HALT: begin
          cur_state <= S_HALT;
        end
        S_ERR: begin
          cur_state <= S_ERR;
        end
        default: begin
          cur_state <= S_ERR;
          err_q     <= 1'b1;
        end
      endcase
    end
  end

  // Strobes decode from the registered state and are forced low while rst is
  // high, so a reset mid-transaction never leaks a request.
  assign ifu_req = !rst && (cur_state == S_FETCH_REQ);
  assign ir_we   = !rst && (cur_state == S_FETCH_WAIT) && ifu_rvalid && !expired;
  assign lsu_req = !rst && (cur_state == S_MEM_REQ);
  assign lsu_wen = lsu_req && (op_q == OPC_STORE);
  assign pc_we   = !rst && (cur_state == S_WB);
  assign rf_wen  = pc_we && opc_writes_rd(op_q);

  assign halt    = halt_q;
  assign err     = err_q;
  assign state   = cur_state;
  assign retired = retired_q;

endmodule

// File: doc/ysyx_23060187_multicycle_ctrl.md
YSYX_23060187_MULTICYCLE_CTRL -- requirements
Module: ysyx_23060187_multicycle_ctrl

Interface
REQ-001 SHALL have parameter: TIMEOUT, default 255, maximum cycles spent in any wait state before error.
REQ-002 SHALL have port: clk  input  1  core clock; all state changes on rising edge.
REQ-003 SHALL have port: rst  input  1  reset; synchronous, active-high.
REQ-004 SHALL have port: opcode  input  7  opcode field from the instruction decoder.
REQ-005 SHALL have port: is_ebreak  input  1  decoder flag: current instruction is EBREAK.
REQ-006 SHALL have ports: ifu_req output 1 fetch request; ifu_ready input 1 request accepted; ifu_rvalid input 1 instruction data valid.
REQ-007 SHALL have port: ir_we  output  1  instruction-register load strobe.
REQ-008 SHALL have ports: lsu_req output 1 memory request; lsu_wen output 1 request is a store; lsu_ready input 1 request accepted; lsu_rvalid input 1 access complete.
REQ-009 SHALL have ports: rf_wen output 1 register-file write enable; pc_we output 1 PC-register update strobe.
REQ-010 SHALL have ports: halt output 1 sticky EBREAK stop; err output 1 sticky fault.
REQ-011 SHALL have ports: state output 4 current FSM state (debug); retired output 32 retired-instruction count.

Function
REQ-012 SHALL implement states IDLE, FETCH_REQ, FETCH_WAIT, DECODE, EXEC, MEM_REQ, MEM_WAIT, WB, HALT, ERR.
REQ-013 IDLE SHALL go to FETCH_REQ on the next cycle unconditionally.
REQ-014 FETCH_REQ SHALL drive ifu_req=1 and go to FETCH_WAIT in the cycle after ifu_ready=1 is sampled.
REQ-015 FETCH_WAIT SHALL drive ir_we=1 combinationally in the cycle ifu_rvalid=1 and go to DECODE.
REQ-016 DECODE SHALL go to HALT if is_ebreak=1, to ERR if opcode is not one of LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP-IMM, OP, SYSTEM, otherwise to EXEC.
REQ-017 EXEC SHALL go to MEM_REQ for LOAD/STORE, otherwise to WB.
REQ-018 MEM_REQ SHALL drive lsu_req=1, lsu_wen=1 only for STORE, and go to MEM_WAIT in the cycle after lsu_ready=1 is sampled.
REQ-019 MEM_WAIT SHALL go to WB in the cycle after lsu_rvalid=1 is sampled.
REQ-020 WB SHALL drive pc_we=1 for one cycle and rf_wen=1 except for STORE, BRANCH and SYSTEM, then go to FETCH_REQ.
REQ-021 retired SHALL increment by 1 in each WB cycle and wrap 0xFFFFFFFF -> 0.
REQ-022 Minimum latency with ready/valid held high SHALL be 5 cycles per non-memory instruction and 7 cycles per LOAD/STORE.
REQ-023 A wait counter SHALL clear on entry to each of FETCH_REQ, FETCH_WAIT, MEM_REQ, MEM_WAIT and increment each cycle spent there.
REQ-024 When the wait counter reaches TIMEOUT, the FSM SHALL go to ERR on the next edge, taking priority over a simultaneous ready/rvalid.
REQ-025 HALT and ERR SHALL be terminal until rst; halt=1 in HALT, err=1 in ERR, and all strobes and requests SHALL be 0 there.
REQ-026 ir_we, pc_we, rf_wen, ifu_req, lsu_req and lsu_wen SHALL be 0 in every state not named for them above.
REQ-027 ifu_rvalid and lsu_rvalid SHALL be ignored outside FETCH_WAIT and MEM_WAIT respectively.

Reset
REQ-028 On rst=1 at a clock edge, state SHALL become IDLE, retired 0, wait counter 0, and halt and err 0.
REQ-029 While rst=1, all request and strobe outputs SHALL be 0, even mid-transaction, and no partial-transaction state SHALL be retained.

Structure
REQ-030 The state encoding and the RV32I opcode constants SHALL live in shared package ysyx_23060187_ctrl_pkg.
REQ-031 The wait counter SHALL be sub-module ysyx_23060187_wait_timer (inputs clear, run; output expired; parameter TIMEOUT).

Verification
REQ-032 The bench SHALL cover: reset, then OP-IMM (0010011) with ready/rvalid always 1 -> ir_we in cycle 3 and WB in cycle 6 with rf_wen=1 and pc_we=1; retired=1.
REQ-033 The bench SHALL cover: LOAD (0000011) with lsu_ready delayed 3 cycles -> lsu_req held 4 cycles, lsu_wen=0, rf_wen=1 in WB.
REQ-034 The bench SHALL cover: STORE (0100011) -> lsu_wen=1 during MEM_REQ and rf_wen=0 in WB.
REQ-035 The bench SHALL cover: is_ebreak=1 at DECODE -> halt=1 next cycle, sticky for 20 cycles, with no ifu_req.
REQ-036 The bench SHALL cover: ifu_ready held 0 with TIMEOUT=8 -> err=1 after 8 wait cycles; then rst=1 for 1 cycle -> IDLE and err=0.
REQ-037 The bench SHALL cover: retired preloaded to 0xFFFFFFFF by forcing, then one retire -> retired=0.
